// File: rtl/pipe_scoreboard_pkg.sv
// Shared definitions for the pipeline scoreboard: register-file geometry,
// writeback depth, producer-latency width and forwarding-select encodings.
package pipe_scoreboard_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int NUM_REGS          = 32;
  localparam int WB_DEPTH          = 3;
  localparam int LAT_W             = 2;
  localparam int FWD_SEL_LEN       = LAT_W;

  // Forwarding select encodings: value = cycles the producer is before commit.
  localparam logic [FWD_SEL_LEN-1:0] FWD_SEL_RF  = FWD_SEL_LEN'(0);  // read the regfile
  localparam logic [FWD_SEL_LEN-1:0] FWD_SEL_WB  = FWD_SEL_LEN'(1);  // WB-stage result
  localparam logic [FWD_SEL_LEN-1:0] FWD_SEL_MEM = FWD_SEL_LEN'(2);  // MEM-stage ALU result

endpackage

// File: rtl/pipe_scoreboard_sb_entry.sv
// sb_entry: one architectural register's scoreboard slot. Holds the pair of
// down-counters pend (cycles until the regfile holds the value) and rdy
// (cycles until the value can be forwarded). A load overrides the decrement,
// so the newest writer always owns the slot.
module sb_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_pend,
  input  logic [LAT_W-1:0] i_rdy,
  output logic [LAT_W-1:0] o_pend,
  output logic [LAT_W-1:0] o_rdy,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_pend;
  logic [LAT_W-1:0] r_rdy;

  // Load on a new writer, otherwise count both counters down to zero and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_rdy  <= '0;
    end else if (i_load) begin
      // NOTE: sequential state uses non-blocking assignments so every entry
      // samples the same pre-edge values regardless of evaluation order.
      r_pend <= i_pend;
      r_rdy  <= i_rdy;
    end else begin
      if (r_pend != '0) r_pend <= r_pend - 1'b1;
      if (r_rdy  != '0) r_rdy  <= r_rdy  - 1'b1;
    end
  end

  assign o_pend = r_pend;
  assign o_rdy  = r_rdy;
  assign o_busy = (r_pend != '0) || (r_rdy != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: countdown-scoreboard hazard and forwarding controller that
// sits beside the ID stage. Produces the ID/IF freeze, the issue strobe and a
// per-source forwarding select that travels down ID2EXE.
// Optional feature macro: SB_PERF_CNT_EN adds the stall_cycles counter output.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = pipe_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W   = REG_FILE_ADDR_LEN,
  parameter int WB_DEPTH = pipe_scoreboard_pkg::WB_DEPTH,
  parameter int LAT_W    = pipe_scoreboard_pkg::LAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              flush,
  input  logic              forward_en,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wb_en,
  input  logic [LAT_W-1:0]  lat,
  output logic              stall,
  output logic              issue_fire,
  output logic [LAT_W-1:0]  src1_fwd_sel,
  output logic [LAT_W-1:0]  src2_fwd_sel
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic [LAT_W-1:0] w_pend [NUM_REGS];
  logic [LAT_W-1:0] w_rdy  [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [LAT_W-1:0] w_lat_c;
  logic             w_load_any;
  logic             w_haz1;
  logic             w_haz2;

  // r0 is hard-wired zero and never becomes pending.
  assign w_pend[0] = '0;
  assign w_rdy[0]  = '0;
  assign w_busy[0] = 1'b0;

  // Clamp the producer latency into 1..WB_DEPTH.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // and no latch is inferred.
    w_lat_c = lat;
    if (lat == '0)                 w_lat_c = LAT_W'(1);
    else if (32'(lat) > WB_DEPTH)  w_lat_c = LAT_W'(WB_DEPTH);
  end

  assign w_load_any = issue_fire & wb_en & (dest != '0);

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load_any && (dest == ADDR_W'(g))),
      .i_pend (LAT_W'(WB_DEPTH - 1)),
      .i_rdy  (w_lat_c - 1'b1),
      .o_pend (w_pend[g]),
      .o_rdy  (w_rdy[g]),
      .o_busy (w_busy[g])
    );
  end

  // Source hazards use pre-update counters; an instruction reading its own
  // destination therefore only sees the older producer.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    if (src1_used && src1 != '0)
      w_haz1 = forward_en ? (w_rdy[src1] != '0) : (w_pend[src1] != '0);
    if (src2_used && src2 != '0)
      w_haz2 = forward_en ? (w_rdy[src2] != '0) : (w_pend[src2] != '0);
  end

  assign stall      = issue_valid & (w_haz1 | w_haz2);
  assign issue_fire = issue_valid & ~stall & ~flush;

  // Forwarding select is the producer's distance from commit; regfile otherwise.
  always_comb begin
    src1_fwd_sel = FWD_SEL_RF;
    src2_fwd_sel = FWD_SEL_RF;
    if (forward_en && src1_used && src1 != '0) src1_fwd_sel = w_pend[src1];
    if (forward_en && src2_used && src2 != '0) src2_fwd_sel = w_pend[src2];
  end

`ifdef SB_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Count cycles lost to hazards on instructions that were not squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_stall_cycles <= '0;
    else if (stall & ~flush) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
